// File: rtl/pc_sequencer_if.sv
// Program-counter update interface between the fetch/decode/execute sequencer
// (master) and its environment (slave): memory, register file, PSR and PC.
//
// Master inputs : instr, instr_valid, flags {C,L,F,Z,N}, rtarget, pc_in, stall
// Master outputs: fetch_req, ir, pc_en, new_adr, imm, link_we, link_data, halted
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic [15:0]      instr;
  logic             instr_valid;
  logic [4:0]       flags;
  logic [WIDTH-1:0] rtarget;
  logic [WIDTH-1:0] pc_in;
  logic             stall;

  logic             fetch_req;
  logic [15:0]      ir;
  logic [1:0]       pc_en;
  logic [WIDTH-1:0] new_adr;
  logic [WIDTH-1:0] imm;
  logic             link_we;
  logic [WIDTH-1:0] link_data;
  logic             halted;

  modport master (
    input  instr, instr_valid, flags, rtarget, pc_in, stall,
    output fetch_req, ir, pc_en, new_adr, imm, link_we, link_data, halted
  );

  modport slave (
    output instr, instr_valid, flags, rtarget, pc_in, stall,
    input  fetch_req, ir, pc_en, new_adr, imm, link_we, link_data, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH -> DECODE -> EXEC sequencer that drives one PC-update
// command per retired instruction.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - pc_sequencer_if.master: instruction fetch handshake, PSR flags,
//           register target, PC value, stall; PC command (pc_en/new_adr/imm),
//           link register write (link_we/link_data), halted.
//
// pc_en: 00 hold, 01 increment, 10 load new_adr, 11 add imm.
//
// Optional feature (macro PC_HALT_DETECT_EN): a taken branch-to-self
// (ir[7:0] == 0) parks the sequencer in a HALT state until reset.
module pc_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DISP_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

`ifdef PC_HALT_DETECT_EN
  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;
`else
  typedef enum logic [1:0] {StFetch, StDecode, StExec} state_e;
`endif

  typedef enum logic [1:0] {ClsOther, ClsBr, ClsJcond, ClsJal} class_e;

  localparam logic [1:0] PcHold = 2'b00;
  localparam logic [1:0] PcInc  = 2'b01;
  localparam logic [1:0] PcLoad = 2'b10;
  localparam logic [1:0] PcAdd  = 2'b11;

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [15:0]      ir_q, ir_d;
  logic [1:0]       pc_en_q, pc_en_d;
  logic [WIDTH-1:0] new_adr_q, new_adr_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             link_we_q, link_we_d;
  logic [WIDTH-1:0] link_data_q, link_data_d;
  logic             fetch_req;
  logic             cond_taken;
  logic [WIDTH-1:0] disp_sext;

  // Flag layout: {C,L,F,Z,N}; even codes test a flag, odd codes its complement.
  function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] f);
    logic c, l, fl, z, n;
    c  = f[4];
    l  = f[3];
    fl = f[2];
    z  = f[1];
    n  = f[0];
    case (cc)
      4'h0:    cond_met = z;
      4'h1:    cond_met = !z;
      4'h2:    cond_met = c;
      4'h3:    cond_met = !c;
      4'h4:    cond_met = l;
      4'h5:    cond_met = !l;
      4'h6:    cond_met = n;
      4'h7:    cond_met = !n;
      4'h8:    cond_met = fl;
      4'h9:    cond_met = !fl;
      4'hA:    cond_met = !l && !z;
      4'hB:    cond_met = l || z;
      4'hC:    cond_met = !n && !z;
      4'hD:    cond_met = n || z;
      4'hE:    cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  function automatic class_e classify(input logic [15:0] i);
    classify = ClsOther;
    if (i[15:12] == 4'b1100) begin
      classify = ClsBr;
    end else if (i[15:12] == 4'b0100 && i[7:4] == 4'b1100) begin
      classify = ClsJcond;
    end else if (i[15:12] == 4'b0100 && i[7:4] == 4'b1000) begin
      classify = ClsJal;
    end
  endfunction

  assign cond_taken = cond_met(ir_q[11:8], bus.flags);
  assign disp_sext  = {{(WIDTH-DISP_W){ir_q[DISP_W-1]}}, ir_q[DISP_W-1:0]};

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    ir_d        = ir_q;
    pc_en_d     = PcHold;
    new_adr_d   = new_adr_q;
    imm_d       = imm_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    fetch_req   = 1'b0;

    case (state_q)
      StFetch: begin
        fetch_req = 1'b1;
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        class_d = classify(ir_q);
        state_d = StExec;
      end
      StExec: begin
        if (!bus.stall) begin
          state_d = StFetch;
          unique case (class_q)
            ClsOther: pc_en_d = PcInc;
            ClsBr: begin
              if (cond_taken) begin
`ifdef PC_HALT_DETECT_EN
                if (ir_q[DISP_W-1:0] == '0) begin
                  state_d = StHalt;
                end else begin
                  pc_en_d = PcAdd;
                  imm_d   = disp_sext;
                end
`else
                pc_en_d = PcAdd;
                imm_d   = disp_sext;
`endif
              end else begin
                pc_en_d = PcInc;
              end
            end
            ClsJcond: begin
              if (cond_taken) begin
                pc_en_d   = PcLoad;
                new_adr_d = bus.rtarget;
              end else begin
                pc_en_d = PcInc;
              end
            end
            ClsJal: begin
              pc_en_d     = PcLoad;
              new_adr_d   = bus.rtarget;
              link_we_d   = 1'b1;
              link_data_d = bus.pc_in + {{(WIDTH-1){1'b0}}, 1'b1};
            end
          endcase
        end
      end
`ifdef PC_HALT_DETECT_EN
      StHalt: begin
        state_d = StHalt;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      class_q     <= ClsOther;
      ir_q        <= '0;
      pc_en_q     <= PcHold;
      new_adr_q   <= '0;
      imm_q       <= '0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      ir_q        <= ir_d;
      pc_en_q     <= pc_en_d;
      new_adr_q   <= new_adr_d;
      imm_q       <= imm_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
    end
  end

  assign bus.fetch_req = fetch_req;
  assign bus.ir        = ir_q;
  assign bus.pc_en     = pc_en_q;
  assign bus.new_adr   = new_adr_q;
  assign bus.imm       = imm_q;
  assign bus.link_we   = link_we_q;
  assign bus.link_data = link_data_q;
`ifdef PC_HALT_DETECT_EN
  assign bus.halted    = (state_q == StHalt);
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer and the initiator side of the program counter update interface.
- Fetches a 16-bit instruction and latches it in the IR.
- Resolves Bcond, Jcond and JAL against the PSR flags.
- Drives exactly one PC-update command per retired instruction: en code, absolute target, and sign-extended displacement.

Parameters:
- WIDTH, 16, datapath/address width.
- DISP_W, 8, branch displacement field width (instr[7:0]).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction word from memory.
- instr_valid  in  1  memory data valid; qualifies instr during FETCH.
- flags  in  5  PSR {C,L,F,Z,N}, bit 4 = C, bit 0 = N.
- rtarget  in  16  register-file read of instr[3:0].
- pc_in  in  16  current PC value.
- stall  in  1  holds EXEC while high.
- fetch_req  out  1  memory read request.
- ir  out  16  latched instruction.
- pc_en  out  2  00 hold, 01 increment, 10 load new_adr, 11 add imm.
- new_adr  out  16  absolute jump target.
- imm  out  16  sign-extended branch displacement.
- link_we  out  1  write-enable for the link register instr[11:8].
- link_data  out  16  pc_in+1 for JAL.
- halted  out  1  halt indication (optional feature only; tied 0 otherwise).

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk.
  - reset high at an edge forces state=FETCH, ir=0, pc_en=00, new_adr=0, imm=0, link_we=0, halted=0.
  - fetch_req is combinational from state, so it is 1 in the first FETCH cycle after reset.
  - Reset mid-instruction aborts that instruction; no PC command and no link write is issued.
- States: FETCH -> DECODE -> EXEC -> FETCH.
  - FETCH: fetch_req=1. On instr_valid=1, ir<=instr and go to DECODE. Otherwise stay in FETCH.
  - DECODE: fetch_req=0. Classify ir as BR (ir[15:12]=1100), JCOND (ir[15:12]=0100, ir[7:4]=1100), JAL (ir[15:12]=0100, ir[7:4]=1000) or OTHER. Always go to EXEC.
  - EXEC with stall=1: hold in EXEC; pc_en=00 and link_we=0.
  - EXEC with stall=0: issue a one-cycle command, registered so it appears in the cycle after the EXEC edge, then go to FETCH.
- EXEC command by class:
  - OTHER: pc_en=01.
  - BR taken: pc_en=11, imm=sign-extended ir[7:0]. BR not taken: pc_en=01.
  - JCOND taken: pc_en=10, new_adr=rtarget. JCOND not taken: pc_en=01.
  - JAL: always taken; pc_en=10, new_adr=rtarget, link_we=1, link_data=pc_in+1 (mod 2^16).
- pc_en and link_we are single-cycle pulses; pc_en=00 in every other cycle.
- imm and new_adr hold their last value between commands.
- Condition field is ir[11:8]:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 HI: L. 5 LS: !L.
  - 6 GT: N. 7 LE: !N.
  - 8 FS: F. 9 FC: !F.
  - A LO: !L&!Z. B HS: L|Z.
  - C LT: !N&!Z. D GE: N|Z.
  - E UC: always. F: never.
- flags are sampled in the EXEC cycle that issues the command.
- Arithmetic: sign extension copies ir[7] into bits 15:8. Displacement 0x80 gives imm=0xFF80. Wrap of the PC is the consumer's concern.
- Throughput: 3 cycles per instruction plus FETCH wait cycles plus stall cycles.

Optional Feature:
- Macro: PC_HALT_DETECT_EN.
- Defined:
  - A taken BR with ir[7:0]=0x00 (branch-to-self) enters state HALT instead of issuing pc_en=11.
  - In HALT: halted=1, pc_en=00, fetch_req=0, link_we=0.
  - HALT is left only by reset.
- Undefined:
  - The HALT state does not exist and halted is tied 0.
  - Branch-to-self issues pc_en=11, imm=0x0000, as for any taken branch.

Test Plan:
- Reset, then instr=0x0000 (OTHER) with instr_valid on the first FETCH cycle: fetch_req=1 right after reset; exactly one pc_en=01 pulse 3 cycles after instr_valid; ir=0x0000.
- BEQ back, instr=0xC0FE:
  - Z=1: pc_en=11, imm=0xFFFE.
  - Z=0: pc_en=01, imm unchanged.
- JUC, instr=0x4EC5, rtarget=0x1234: pc_en=10, new_adr=0x1234. Same instruction as JFS (0x48C5) with F=0: pc_en=01.
- JAL, instr=0x4A83, rtarget=0x0040, pc_in=0xFFFF: pc_en=10, new_adr=0x0040, link_we=1, link_data=0x0000 (wrap), all single-cycle.
- Hold cases:
  - stall=1 for 4 cycles in EXEC: no pc_en pulse until stall drops, then one pulse.
  - instr_valid held low 5 cycles: FETCH holds with fetch_req=1.
  - reset asserted in DECODE: no pc_en pulse; next state is FETCH.
- With PC_HALT_DETECT_EN: instr=0xCE00 → halted=1 and pc_en=00 for 20 cycles; reset clears halted. Without the macro: same instruction gives pc_en=11, imm=0x0000.
